// File: rtl/pc_unit.sv
// Program-counter stage: holds the fetch PC, selects PC+4 / branch target, sequences imem fetches.
// Latency: pc updates on the edge where an advance happens; instrValid pulses the cycle after.
// Backpressure: imem_ready=0 or stall=1 holds pc and re-presents it; a branch seen meanwhile is parked.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   branchMux           branch-taken strobe (one cycle), branchOffset = signed word offset
//   stall               hold the PC (hazard)
//   halt                enter HALT until reset
//   imem_ready          instruction memory accepts the presented pc
//   imem_req            fetch request for pc (state-decoded, registered)
//   pc / pcPlus4        current fetch address / pc + 4 (combinational)
//   instrValid          fetch of the previous pc was accepted
//   branchCount         saturating taken-branch counter, present only when
//                       PC_BRANCH_COUNT_EN is defined
module pc_unit #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             branchMux,
    input  logic [WIDTH-1:0] branchOffset,
    input  logic             stall,
    input  logic             halt,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pcPlus4,
    output logic             instrValid
`ifdef PC_BRANCH_COUNT_EN
    ,
    output logic [31:0]      branchCount
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             pend_vld;
    logic [WIDTH-1:0] pend_tgt;

    logic             advance;
    logic             take_branch;
    logic [WIDTH-1:0] branch_tgt;
    logic [WIDTH-1:0] pc_nxt;

    assign pcPlus4 = pc + WIDTH'(4);

    // Word offset scaled to bytes; everything wraps modulo 2^WIDTH.
    assign branch_tgt = pcPlus4 + (branchOffset << 2);

    // halt wins over advance: the PC must not move on the edge that enters HALT.
    assign advance = (state == FETCH) && imem_ready && !stall && !halt;

    // A live branch beats a parked one; either counts as a taken branch.
    assign take_branch = advance && (branchMux || pend_vld);

    // ------------------------------------------------------------------
    // Next-state / next-PC logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = halt ? HALT : FETCH;
            FETCH:   state_nxt = halt ? HALT : FETCH;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pc_nxt = pc;
        if (advance) begin
            if (branchMux)
                pc_nxt = branch_tgt;
            else if (pend_vld)
                pc_nxt = pend_tgt;
            else
                pc_nxt = pcPlus4;
        end
    end

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            instrValid <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            // Request decoded from the next state so it is a flop output,
            // with no path from imem_ready.
            imem_req   <= (state_nxt == FETCH);
            instrValid <= advance;
        end
    end

    // Pending branch: a branch that arrives while the PC is held is parked
    // here and consumed by the next advance. Newest branch overwrites.
    // Only FETCH can park one; IDLE/HALT ignore branchMux and entering
    // HALT drops anything parked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld <= 1'b0;
            pend_tgt <= {WIDTH{1'b0}};
        end else if (state != FETCH || halt) begin
            pend_vld <= 1'b0;
        end else if (advance) begin
            pend_vld <= 1'b0;
        end else if (branchMux) begin
            pend_vld <= 1'b1;
            pend_tgt <= branch_tgt;
        end
    end

`ifdef PC_BRANCH_COUNT_EN
    // Saturating count of advances that took a branch (live or parked).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            branchCount <= 32'd0;
        else if (take_branch && branchCount != 32'hFFFF_FFFF)
            branchCount <= branchCount + 32'd1;
    end
`else
    // Keep the decode visible without building a counter.
    logic unused_take_branch;
    assign unused_take_branch = take_branch;
`endif

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        branchMux;
    logic [31:0] branchOffset;
    logic        stall;
    logic        halt;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        instrValid;
`ifdef PC_BRANCH_COUNT_EN
    logic [31:0] branchCount;
`endif

    int vectors;
    int miscompares;

    pc_unit #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .branchMux    (branchMux),
        .branchOffset (branchOffset),
        .stall        (stall),
        .halt         (halt),
        .imem_ready   (imem_ready),
        .imem_req     (imem_req),
        .pc           (pc),
        .pcPlus4      (pcPlus4),
        .instrValid   (instrValid)
`ifdef PC_BRANCH_COUNT_EN
        ,
        .branchCount  (branchCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        branchMux    = 1'b0;
        branchOffset = 32'd0;
        stall        = 1'b0;
        halt         = 1'b0;
        imem_ready   = 1'b1;

        // ---- reset state ----
        #12;
        chk("rst_pc",       pc,               32'h100);
        chk("rst_pcplus4",  pcPlus4,          32'h104);
        chk("rst_req",      32'(imem_req),    32'd0);
        chk("rst_ivalid",   32'(instrValid),  32'd0);
`ifdef PC_BRANCH_COUNT_EN
        chk("rst_bcnt",     branchCount,      32'd0);
`endif
        rst_n = 1'b1;

        // ---- reset release, sequential fetch ----
        tick;  // IDLE -> FETCH
        chk("idle_pc",      pc,               32'h100);
        chk("idle_req",     32'(imem_req),    32'd1);
        chk("idle_ivalid",  32'(instrValid),  32'd0);
        tick;
        chk("seq1_pc",      pc,               32'h104);
        chk("seq1_ivalid",  32'(instrValid),  32'd1);
        tick;
        chk("seq2_pc",      pc,               32'h108);
        chk("seq2_ivalid",  32'(instrValid),  32'd1);

        // ---- taken branches: 0x108 -> 0x200 -> 0x1FC -> 0x40 ----
        branchMux    = 1'b1;
        branchOffset = 32'd61;
        tick;
        chk("br_fwd_pc",    pc,               32'h200);
        branchOffset = 32'hFFFF_FFFE;  // -2
        tick;
        chk("br_back_pc",   pc,               32'h1FC);
`ifdef PC_BRANCH_COUNT_EN
        chk("br_back_bcnt", branchCount,      32'd2);
`endif
        branchOffset = 32'hFFFF_FF90;  // -112
        tick;
        chk("br_to40_pc",   pc,               32'h40);

        // ---- branch during stall ----
        stall        = 1'b1;
        branchOffset = 32'd3;
        tick;
        chk("stl1_pc",      pc,               32'h40);
        chk("stl1_req",     32'(imem_req),    32'd1);
        chk("stl1_ivalid",  32'(instrValid),  32'd0);
        branchMux    = 1'b0;
        branchOffset = 32'd0;
        tick;
        chk("stl2_pc",      pc,               32'h40);
        stall = 1'b0;
        tick;
        chk("stl_pend_pc",  pc,               32'h50);
        chk("stl_pend_iv",  32'(instrValid),  32'd1);
        tick;  // pending must be gone: plain +4
        chk("stl_clr_pc",   pc,               32'h54);
`ifdef PC_BRANCH_COUNT_EN
        chk("stl_bcnt",     branchCount,      32'd4);
`endif

        // ---- wait on memory at 0x80 ----
        branchMux    = 1'b1;
        branchOffset = 32'd10;
        tick;
        chk("to80_pc",      pc,               32'h80);
        branchMux    = 1'b0;
        branchOffset = 32'd0;
        imem_ready   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("wait_pc",     pc,              32'h80);
            chk("wait_req",    32'(imem_req),   32'd1);
            chk("wait_ivalid", 32'(instrValid), 32'd0);
        end
        imem_ready = 1'b1;
        tick;
        chk("wait_done_pc", pc,               32'h84);
        chk("wait_done_iv", 32'(instrValid),  32'd1);

        // ---- async reset with a pending branch ----
        stall        = 1'b1;
        branchMux    = 1'b1;
        branchOffset = 32'd5;
        tick;
        chk("ar_hold_pc",   pc,               32'h84);
        branchMux    = 1'b0;
        branchOffset = 32'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_pc",        pc,               32'h100);
        chk("ar_req",       32'(imem_req),    32'd0);
        chk("ar_ivalid",    32'(instrValid),  32'd0);
`ifdef PC_BRANCH_COUNT_EN
        chk("ar_bcnt",      branchCount,      32'd0);
`endif
        stall = 1'b0;
        tick;
        #2 rst_n = 1'b1;
        tick;  // IDLE -> FETCH
        chk("ar_idle_pc",   pc,               32'h100);
        chk("ar_idle_req",  32'(imem_req),    32'd1);
        tick;  // first advance: parked branch must not resurface
        chk("ar_adv_pc",    pc,               32'h104);

        // ---- halt vs advance at 0x10 ----
        branchMux    = 1'b1;
        branchOffset = 32'hFFFF_FFC2;  // -62
        tick;
        chk("to10_pc",      pc,               32'h10);
        branchMux    = 1'b0;
        branchOffset = 32'd0;
        halt         = 1'b1;
        tick;
        chk("halt_pc",      pc,               32'h10);
        chk("halt_req",     32'(imem_req),    32'd0);
        chk("halt_ivalid",  32'(instrValid),  32'd0);
        halt         = 1'b0;
        branchMux    = 1'b1;
        branchOffset = 32'd7;
        tick;
        tick;
        chk("halt_br_pc",   pc,               32'h10);
        chk("halt_br_req",  32'(imem_req),    32'd0);
        chk("halt_br_iv",   32'(instrValid),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
